// File: rtl/gpr_writeback_if.sv
// Write-back bundle: ALU/LSU result sources, issue tap, scoreboard
// and register file write port.
interface gpr_writeback_if #(
    parameter int ADDR_WIDTH = 5,
    parameter int DATA_WIDTH = 64
);
    localparam int NREGS = 1 << ADDR_WIDTH;

    logic                  alu_valid;
    logic                  alu_ready;
    logic [ADDR_WIDTH-1:0] alu_rd;
    logic [DATA_WIDTH-1:0] alu_data;

    logic                  lsu_valid;
    logic                  lsu_ready;
    logic [ADDR_WIDTH-1:0] lsu_rd;
    logic [DATA_WIDTH-1:0] lsu_data;

    logic                  iss_valid;
    logic [ADDR_WIDTH-1:0] iss_rd;
    logic [NREGS-1:0]      busy;

    logic                  rf_wen;
    logic [ADDR_WIDTH-1:0] rf_rd;
    logic [DATA_WIDTH-1:0] rf_data;

    modport master (
        output alu_valid, alu_rd, alu_data,
        output lsu_valid, lsu_rd, lsu_data,
        output iss_valid, iss_rd,
        input  alu_ready, lsu_ready, busy,
        input  rf_wen, rf_rd, rf_data
    );

    modport slave (
        input  alu_valid, alu_rd, alu_data,
        input  lsu_valid, lsu_rd, lsu_data,
        input  iss_valid, iss_rd,
        output alu_ready, lsu_ready, busy,
        output rf_wen, rf_rd, rf_data
    );
endinterface

// File: rtl/gpr_writeback.sv
// GPR write-back: ALU/LSU arbitration with LSU anti-starvation,
// registered RF write port with x0 suppression, busy scoreboard.
module gpr_writeback #(
    parameter int ADDR_WIDTH = 5,
    parameter int DATA_WIDTH = 64,
    parameter int STARVE_MAX = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    gpr_writeback_if.slave       wb
);
    localparam int NREGS = 1 << ADDR_WIDTH;
    localparam int CW    = $clog2(STARVE_MAX + 1);
    localparam logic [CW-1:0] SMAX = CW'(STARVE_MAX);

    logic [CW-1:0]         cnt_q;
    logic [CW-1:0]         cnt_d;
    logic                  starve;
    logic                  alu_acc;
    logic                  lsu_acc;
    logic                  acc;
    logic [ADDR_WIDTH-1:0] acc_rd;
    logic [DATA_WIDTH-1:0] acc_data;

    logic                  wen_q;
    logic [ADDR_WIDTH-1:0] rd_q;
    logic [DATA_WIDTH-1:0] data_q;
    logic [NREGS-1:0]      busy_q;
    logic [NREGS-1:0]      busy_d;
    logic [NREGS-1:0]      set_m;
    logic [NREGS-1:0]      clr_m;

    assign starve       = (cnt_q == SMAX);
    assign wb.alu_ready = !starve;
    assign wb.lsu_ready = starve || !wb.alu_valid;

    assign alu_acc = wb.alu_valid && !starve;
    assign lsu_acc = !alu_acc && wb.lsu_valid && wb.lsu_ready;
    assign acc     = alu_acc || lsu_acc;

    always_comb begin
        acc_rd   = wb.lsu_rd;
        acc_data = wb.lsu_data;
        if (alu_acc) begin
            acc_rd   = wb.alu_rd;
            acc_data = wb.alu_data;
        end
    end

    // Counter only advances while the LSU is held off; saturates at SMAX.
    always_comb begin
        cnt_d = cnt_q;
        if (lsu_acc || !wb.lsu_valid)
            cnt_d = '0;
        else if (!wb.lsu_ready && cnt_q != SMAX)
            cnt_d = cnt_q + 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            cnt_q <= '0;
        else
            cnt_q <= cnt_d;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wen_q  <= 1'b0;
            rd_q   <= '0;
            data_q <= '0;
        end else begin
            wen_q <= acc && (acc_rd != '0);
            if (acc) begin
                rd_q   <= acc_rd;
                data_q <= acc_data;
            end
        end
    end

    // Set is applied after clear so a same-edge reissue keeps the bit.
    always_comb begin
        set_m = '0;
        clr_m = '0;
        if (wen_q)
            clr_m[rd_q] = 1'b1;
        if (wb.iss_valid && wb.iss_rd != '0)
            set_m[wb.iss_rd] = 1'b1;
        busy_d    = (busy_q & ~clr_m) | set_m;
        busy_d[0] = 1'b0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            busy_q <= '0;
        else
            busy_q <= busy_d;
    end

    assign wb.busy    = busy_q;
    assign wb.rf_wen  = wen_q;
    assign wb.rf_rd   = rd_q;
    assign wb.rf_data = data_q;
endmodule
